// File: rtl/sb_issue_ctrl_if.sv
// rtl/sb_issue_ctrl_if.sv - Decoder, functional-unit and writeback signal bundle for sb_issue_ctrl
interface sb_issue_ctrl_if #(
    parameter int NFU = 5
);
    logic           id_valid;
    logic           id_ready;
    logic [2:0]     id_fu;
    logic [5:0]     id_reg1;
    logic [5:0]     id_reg2;
    logic           id_r1_val;
    logic           id_r2_val;
    logic [5:0]     id_reg3;
    logic           id_rf_we;
    logic           id_err;
    logic [NFU-1:0] fu_start;
    logic [NFU-1:0] fu_done;
    logic           wb_valid;
    logic [2:0]     wb_fu;
    logic [5:0]     wb_reg;
    logic           wb_we;

    modport master (
        output id_valid, id_fu, id_reg1, id_reg2, id_r1_val, id_r2_val, id_reg3, id_rf_we, fu_done,
        input  id_ready, id_err, fu_start, wb_valid, wb_fu, wb_reg, wb_we
    );

    modport slave (
        input  id_valid, id_fu, id_reg1, id_reg2, id_r1_val, id_r2_val, id_reg3, id_rf_we, fu_done,
        output id_ready, id_err, fu_start, wb_valid, wb_fu, wb_reg, wb_we
    );
endinterface

// File: rtl/sb_issue_ctrl.sv
// rtl/sb_issue_ctrl.sv - Single-entry-per-FU scoreboard: issue, RAW/WAR/WAW tracking, writeback arbitration
module sb_issue_ctrl #(
    parameter int NFU = 5
) (
    input  logic           clk,
    input  logic           resetn,
    sb_issue_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EXEC, S_DONE} state_t;

    localparam logic [3:0] NFU_N = 4'(NFU);

    state_t                   st       [NFU];
    state_t                   st_nxt   [NFU];
    logic [NFU-1:0][5:0]      dst, dst_nxt;
    logic [NFU-1:0]           we, we_nxt;
    logic [NFU-1:0][5:0]      src1, src1_nxt;
    logic [NFU-1:0][5:0]      src2, src2_nxt;
    logic [NFU-1:0]           rdy1, rdy1_nxt;
    logic [NFU-1:0]           rdy2, rdy2_nxt;
    logic [NFU-1:0][2:0]      q1, q1_nxt;
    logic [NFU-1:0][2:0]      q2, q2_nxt;
    logic [63:0]              busy, busy_nxt;
    logic [63:0][2:0]         tag, tag_nxt;
    logic                     err_q;

    logic [NFU-1:0]           start;
    logic [NFU-1:0]           war;
    logic                     grant;
    logic [2:0]               gsel;
    logic [5:0]               g_dst;
    logic                     g_we;
    logic                     fu_ok;
    logic                     tgt_idle;
    logic                     waw;
    logic                     id_ready_c;
    logic                     issue;
    logic                     new_rdy1;
    logic                     new_rdy2;

    // An entry starts as soon as both operands are marked ready
    always_comb begin
        start = '0;
        for (int i = 0; i < NFU; i++) begin
            start[i] = (st[i] == S_WAIT) && rdy1[i] && rdy2[i];
        end
    end

    // WAR: another waiting entry still has to read the register this entry will overwrite
    always_comb begin
        war = '0;
        for (int i = 0; i < NFU; i++) begin
            for (int j = 0; j < NFU; j++) begin
                if (j != i && we[i] && dst[i] != 6'd0 && st[j] == S_WAIT &&
                    ((src1[j] == dst[i] && rdy1[j]) || (src2[j] == dst[i] && rdy2[j]))) begin
                    war[i] = 1'b1;
                end
            end
        end
    end

    // Fixed-priority writeback grant, lowest eligible index wins
    always_comb begin
        grant = 1'b0;
        gsel  = '0;
        g_dst = '0;
        g_we  = 1'b0;
        for (int i = NFU - 1; i >= 0; i--) begin
            if (st[i] == S_DONE && !war[i]) begin
                grant = 1'b1;
                gsel  = 3'(i);
                g_dst = dst[i];
                g_we  = we[i];
            end
        end
    end

    // Issue decision and operand readiness, with bypass of a same-cycle grant
    always_comb begin
        fu_ok    = {1'b0, bus.id_fu} < NFU_N;
        tgt_idle = 1'b0;
        for (int i = 0; i < NFU; i++) begin
            if (bus.id_fu == 3'(i)) begin
                tgt_idle = (st[i] == S_IDLE);
            end
        end
        waw        = bus.id_rf_we && (bus.id_reg3 != 6'd0) && busy[bus.id_reg3];
        id_ready_c = fu_ok ? (tgt_idle && !waw) : 1'b1;
        issue      = bus.id_valid && id_ready_c && fu_ok;
        new_rdy1   = !bus.id_r1_val || (bus.id_reg1 == 6'd0) || !busy[bus.id_reg1] ||
                     (grant && tag[bus.id_reg1] == gsel);
        new_rdy2   = !bus.id_r2_val || (bus.id_reg2 == 6'd0) || !busy[bus.id_reg2] ||
                     (grant && tag[bus.id_reg2] == gsel);
    end

    // Per-entry next state: grant release, start, completion, wake-up and allocation
    always_comb begin
        st_nxt   = st;
        dst_nxt  = dst;
        we_nxt   = we;
        src1_nxt = src1;
        src2_nxt = src2;
        rdy1_nxt = rdy1;
        rdy2_nxt = rdy2;
        q1_nxt   = q1;
        q2_nxt   = q2;
        for (int i = 0; i < NFU; i++) begin
            if (grant && gsel == 3'(i)) begin
                st_nxt[i] = S_IDLE;
            end else begin
                case (st[i])
                    S_WAIT: begin
                        if (start[i]) st_nxt[i] = S_EXEC;
                        if (grant && !rdy1[i] && q1[i] == gsel) rdy1_nxt[i] = 1'b1;
                        if (grant && !rdy2[i] && q2[i] == gsel) rdy2_nxt[i] = 1'b1;
                    end
                    S_EXEC: begin
                        if (bus.fu_done[i]) st_nxt[i] = S_DONE;
                    end
                    default: ;
                endcase
            end
            if (issue && bus.id_fu == 3'(i)) begin
                st_nxt[i]   = S_WAIT;
                dst_nxt[i]  = bus.id_reg3;
                we_nxt[i]   = bus.id_rf_we;
                // Unused sources are stored as r0 so they never look like a pending read
                src1_nxt[i] = bus.id_r1_val ? bus.id_reg1 : 6'd0;
                src2_nxt[i] = bus.id_r2_val ? bus.id_reg2 : 6'd0;
                rdy1_nxt[i] = new_rdy1;
                rdy2_nxt[i] = new_rdy2;
                q1_nxt[i]   = tag[bus.id_reg1];
                q2_nxt[i]   = tag[bus.id_reg2];
            end
        end
    end

    // Result-status table: grant clears its own claim, a same-cycle issue claim overrides
    always_comb begin
        busy_nxt = busy;
        tag_nxt  = tag;
        if (grant && g_we && g_dst != 6'd0 && tag[g_dst] == gsel) begin
            busy_nxt[g_dst] = 1'b0;
        end
        if (issue && bus.id_rf_we && bus.id_reg3 != 6'd0) begin
            busy_nxt[bus.id_reg3] = 1'b1;
            tag_nxt[bus.id_reg3]  = bus.id_fu;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < NFU; i++) begin
                st[i] <= S_IDLE;
            end
            dst   <= '0;
            we    <= '0;
            src1  <= '0;
            src2  <= '0;
            rdy1  <= '0;
            rdy2  <= '0;
            q1    <= '0;
            q2    <= '0;
            busy  <= '0;
            tag   <= '0;
            err_q <= 1'b0;
        end else begin
            st    <= st_nxt;
            dst   <= dst_nxt;
            we    <= we_nxt;
            src1  <= src1_nxt;
            src2  <= src2_nxt;
            rdy1  <= rdy1_nxt;
            rdy2  <= rdy2_nxt;
            q1    <= q1_nxt;
            q2    <= q2_nxt;
            busy  <= busy_nxt;
            tag   <= tag_nxt;
            err_q <= bus.id_valid && !fu_ok;
        end
    end

    assign bus.id_ready = id_ready_c;
    assign bus.id_err   = err_q;
    assign bus.fu_start = start;
    assign bus.wb_valid = grant;
    assign bus.wb_fu    = gsel;
    assign bus.wb_reg   = g_dst;
    assign bus.wb_we    = g_we;
endmodule

// File: tb/tb_sb_issue_ctrl.sv
// tb/tb_sb_issue_ctrl.sv - Self-checking bench for sb_issue_ctrl: directed vector table plus random vs reference model
module tb_sb_issue_ctrl;
    logic clk;
    logic resetn;
    int   n_cmp;
    int   n_bad;

    sb_issue_ctrl_if #(.NFU(5)) bus ();

    sb_issue_ctrl #(.NFU(5)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [2:0] fu;
        logic [5:0] r1;
        logic       u1;
        logic [5:0] r2;
        logic       u2;
        logic [5:0] r3;
        logic       we;
        logic [4:0] done;
        logic       e_rdy;
        logic [4:0] e_start;
        logic       e_wbv;
        logic [2:0] e_wbfu;
        logic [5:0] e_wbreg;
        logic       e_wbwe;
        logic       e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t iss(input logic [2:0] fu, input logic [5:0] r1, input logic u1,
                                 input logic [5:0] r2, input logic u2, input logic [5:0] r3,
                                 input logic we, input logic [4:0] done, input logic e_rdy,
                                 input logic [4:0] e_start, input logic e_wbv, input logic [2:0] e_wbfu,
                                 input logic [5:0] e_wbreg, input logic e_wbwe);
        vec_t r;
        r = '{1'b1, fu, r1, u1, r2, u2, r3, we, done, e_rdy, e_start, e_wbv, e_wbfu, e_wbreg, e_wbwe, 1'b0};
        return r;
    endfunction

    function automatic vec_t nop(input logic [4:0] done, input logic [4:0] e_start, input logic e_wbv,
                                 input logic [2:0] e_wbfu, input logic [5:0] e_wbreg, input logic e_wbwe,
                                 input logic e_err);
        vec_t r;
        r = '{1'b0, 3'd7, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, done, 1'b1, e_start, e_wbv, e_wbfu, e_wbreg,
              e_wbwe, e_err};
        return r;
    endfunction

    task automatic drive(input logic v, input logic [2:0] fu, input logic [5:0] r1, input logic u1,
                         input logic [5:0] r2, input logic u2, input logic [5:0] r3, input logic we,
                         input logic [4:0] done);
        bus.id_valid  = v;
        bus.id_fu     = fu;
        bus.id_reg1   = r1;
        bus.id_r1_val = u1;
        bus.id_reg2   = r2;
        bus.id_r2_val = u2;
        bus.id_reg3   = r3;
        bus.id_rf_we  = we;
        bus.fu_done   = done;
    endtask

    function automatic logic [17:0] obs();
        return {bus.id_ready, bus.fu_start, bus.wb_valid, bus.wb_fu, bus.wb_reg, bus.wb_we, bus.id_err};
    endfunction

    task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got {rdy,start,wbv,wbfu,wbreg,wbwe,err}=%05h required %05h", name, act, exp);
        end
    endtask

    // Reference model: each FU holds one instruction with an age; hazards are judged by age order
    int         m_ph  [5];
    int         m_seq [5];
    logic [5:0] m_dst [5];
    logic [5:0] m_s1  [5];
    logic [5:0] m_s2  [5];
    logic       m_we  [5];
    logic       m_u1  [5];
    logic       m_u2  [5];
    logic       m_err;
    int         seq_ctr;

    function automatic bit writer_pending(input int k, input logic [5:0] r, input bit only_older);
        for (int m = 0; m < 5; m++) begin
            if (m != k && m_ph[m] != 0 && m_we[m] && m_dst[m] == r && r != 6'd0 &&
                (!only_older || m_seq[m] < m_seq[k])) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit m_blocked(input int i);
        if (!m_we[i] || m_dst[i] == 6'd0) return 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k != i && m_ph[k] == 1 && m_seq[k] < m_seq[i] &&
                ((m_u1[k] && m_s1[k] == m_dst[i]) || (m_u2[k] && m_s2[k] == m_dst[i]))) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 5; k++) m_ph[k] = 0;
        m_err   = 1'b0;
        seq_ctr = 0;
    endtask

    task automatic model_cycle(input logic v, input logic [2:0] fu, input logic [5:0] r1, input logic u1,
                               input logic [5:0] r2, input logic u2, input logic [5:0] r3, input logic we,
                               input logic [4:0] done, output logic [17:0] exp);
        logic [4:0] st_e;
        int         g;
        logic       rdy;
        st_e = '0;
        for (int k = 0; k < 5; k++) begin
            if (m_ph[k] == 1 && (!m_u1[k] || !writer_pending(k, m_s1[k], 1'b1)) &&
                (!m_u2[k] || !writer_pending(k, m_s2[k], 1'b1))) st_e[k] = 1'b1;
        end
        g = -1;
        for (int i = 4; i >= 0; i--) begin
            if (m_ph[i] == 3 && !m_blocked(i)) g = i;
        end
        if (fu >= 3'd5) rdy = 1'b1;
        else rdy = (m_ph[fu] == 0) && !(we && r3 != 6'd0 && writer_pending(-1, r3, 1'b0));
        if (g >= 0) exp = {rdy, st_e, 1'b1, 3'(g), m_dst[g], m_we[g], m_err};
        else        exp = {rdy, st_e, 1'b0, 3'd0, 6'd0, 1'b0, m_err};
        for (int k = 0; k < 5; k++) begin
            if (k == g) m_ph[k] = 0;
            else if (m_ph[k] == 1 && st_e[k]) m_ph[k] = 2;
            else if (m_ph[k] == 2 && done[k]) m_ph[k] = 3;
        end
        if (v && fu < 3'd5 && rdy) begin
            m_ph[fu]  = 1;
            m_seq[fu] = seq_ctr;
            seq_ctr++;
            m_dst[fu] = r3;
            m_we[fu]  = we;
            m_s1[fu]  = r1;
            m_u1[fu]  = u1;
            m_s2[fu]  = r2;
            m_u2[fu]  = u2;
        end
        m_err = v && (fu >= 3'd5);
    endtask

    function automatic logic [5:0] pick_reg();
        int s;
        s = $urandom_range(0, 5);
        if (s == 5) return 6'd32;
        return 6'(s);
    endfunction

    initial begin
        logic [17:0] exp;
        logic        rv, ru1, ru2, rwe;
        logic [2:0]  rfu;
        logic [5:0]  rr1, rr2, rr3;
        logic [4:0]  rdone;
        n_cmp = 0;
        n_bad = 0;

        // independent ops
        tbl.push_back(iss(0, 1, 1, 0, 0, 3, 1, 0, 1, 5'b00000, 0, 0, 0, 0));
        tbl.push_back(iss(3, 2, 1, 0, 0, 4, 1, 0, 1, 5'b00001, 0, 0, 0, 0));
        tbl.push_back(nop(5'b00000, 5'b01000, 0, 0, 0, 0, 0));
        tbl.push_back(nop(5'b00000, 5'b00000, 0, 0, 0, 0, 0));
        tbl.push_back(nop(5'b00000, 5'b00000, 0, 0, 0, 0, 0));
        tbl.push_back(nop(5'b01001, 5'b00000, 0, 0, 0, 0, 0));
        tbl.push_back(nop(5'b00000, 5'b00000, 1, 0, 3, 1, 0));
        tbl.push_back(nop(5'b00000, 5'b00000, 1, 3, 4, 1, 0));
        tbl.push_back(nop(5'b00000, 5'b00000, 0, 0, 0, 0, 0));
        // RAW on r5
        tbl.push_back(iss(0, 0, 0, 0, 0, 5, 1, 0, 1, 5'b00000, 0, 0, 0, 0));
        tbl.push_back(iss(3, 5, 1, 0, 0, 6, 1, 0, 1, 5'b00001, 0, 0, 0, 0));
        tbl.push_back(nop(5'b00000, 5'b00000, 0, 0, 0, 0, 0));
        tbl.push_back(nop(5'b00001, 5'b00000, 0, 0, 0, 0, 0));
        tbl.push_back(nop(5'b00000, 5'b00000, 1, 0, 5, 1, 0));
        tbl.push_back(nop(5'b00000, 5'b01000, 0, 0, 0, 0, 0));
        tbl.push_back(nop(5'b01000, 5'b00000, 0, 0, 0, 0, 0));
        tbl.push_back(nop(5'b00000, 5'b00000, 1, 3, 6, 1, 0));
        tbl.push_back(nop(5'b00000, 5'b00000, 0, 0, 0, 0, 0));
        // WAW on r7 plus structural stall on fu0
        tbl.push_back(iss(0, 0, 0, 0, 0, 7, 1, 0, 1, 5'b00000, 0, 0, 0, 0));
        tbl.push_back(iss(0, 0, 0, 0, 0, 9, 1, 0, 0, 5'b00001, 0, 0, 0, 0));
        tbl.push_back(iss(4, 0, 0, 0, 0, 7, 1, 5'b00001, 0, 5'b00000, 0, 0, 0, 0));
        tbl.push_back(iss(4, 0, 0, 0, 0, 7, 1, 0, 0, 5'b00000, 1, 0, 7, 1));
        tbl.push_back(iss(4, 0, 0, 0, 0, 7, 1, 0, 1, 5'b00000, 0, 0, 0, 0));
        tbl.push_back(nop(5'b00000, 5'b10000, 0, 0, 0, 0, 0));
        tbl.push_back(nop(5'b10000, 5'b00000, 0, 0, 0, 0, 0));
        tbl.push_back(nop(5'b00000, 5'b00000, 1, 4, 7, 1, 0));
        tbl.push_back(nop(5'b00000, 5'b00000, 0, 0, 0, 0, 0));
        // WAR on r2
        tbl.push_back(iss(1, 0, 0, 0, 0, 10, 1, 0, 1, 5'b00000, 0, 0, 0, 0));
        tbl.push_back(iss(3, 2, 1, 10, 1, 11, 1, 0, 1, 5'b00010, 0, 0, 0, 0));
        tbl.push_back(iss(0, 0, 0, 0, 0, 2, 1, 0, 1, 5'b00000, 0, 0, 0, 0));
        tbl.push_back(nop(5'b00000, 5'b00001, 0, 0, 0, 0, 0));
        tbl.push_back(nop(5'b00001, 5'b00000, 0, 0, 0, 0, 0));
        tbl.push_back(nop(5'b00010, 5'b00000, 0, 0, 0, 0, 0));
        tbl.push_back(nop(5'b00000, 5'b00000, 1, 1, 10, 1, 0));
        tbl.push_back(nop(5'b00000, 5'b01000, 0, 0, 0, 0, 0));
        tbl.push_back(nop(5'b00000, 5'b00000, 1, 0, 2, 1, 0));
        tbl.push_back(nop(5'b01000, 5'b00000, 0, 0, 0, 0, 0));
        tbl.push_back(nop(5'b00000, 5'b00000, 1, 3, 11, 1, 0));
        tbl.push_back(nop(5'b00000, 5'b00000, 0, 0, 0, 0, 0));
        // simultaneous completion, fixed priority
        tbl.push_back(iss(2, 0, 0, 0, 0, 12, 1, 0, 1, 5'b00000, 0, 0, 0, 0));
        tbl.push_back(iss(4, 0, 0, 0, 0, 13, 1, 0, 1, 5'b00100, 0, 0, 0, 0));
        tbl.push_back(nop(5'b00000, 5'b10000, 0, 0, 0, 0, 0));
        tbl.push_back(nop(5'b10100, 5'b00000, 0, 0, 0, 0, 0));
        tbl.push_back(nop(5'b00000, 5'b00000, 1, 2, 12, 1, 0));
        tbl.push_back(nop(5'b00000, 5'b00000, 1, 4, 13, 1, 0));
        tbl.push_back(nop(5'b00000, 5'b00000, 0, 0, 0, 0, 0));
        // out-of-range FU
        tbl.push_back(iss(7, 0, 0, 0, 0, 0, 0, 0, 1, 5'b00000, 0, 0, 0, 0));
        tbl.push_back(nop(5'b00000, 5'b00000, 0, 0, 0, 0, 1));
        tbl.push_back(nop(5'b00000, 5'b00000, 0, 0, 0, 0, 0));
        // issue reading a register granted in the same cycle
        tbl.push_back(iss(0, 0, 0, 0, 0, 14, 1, 0, 1, 5'b00000, 0, 0, 0, 0));
        tbl.push_back(nop(5'b00000, 5'b00001, 0, 0, 0, 0, 0));
        tbl.push_back(nop(5'b00001, 5'b00000, 0, 0, 0, 0, 0));
        tbl.push_back(iss(1, 14, 1, 0, 0, 15, 1, 0, 1, 5'b00000, 1, 0, 14, 1));
        tbl.push_back(nop(5'b00000, 5'b00010, 0, 0, 0, 0, 0));
        tbl.push_back(nop(5'b00010, 5'b00000, 0, 0, 0, 0, 0));
        tbl.push_back(nop(5'b00000, 5'b00000, 1, 1, 15, 1, 0));
        tbl.push_back(nop(5'b00000, 5'b00000, 0, 0, 0, 0, 0));
        // op without register write
        tbl.push_back(iss(2, 0, 0, 0, 0, 20, 0, 0, 1, 5'b00000, 0, 0, 0, 0));
        tbl.push_back(nop(5'b00000, 5'b00100, 0, 0, 0, 0, 0));
        tbl.push_back(nop(5'b00100, 5'b00000, 0, 0, 0, 0, 0));
        tbl.push_back(nop(5'b00000, 5'b00000, 1, 2, 20, 0, 0));
        tbl.push_back(nop(5'b00000, 5'b00000, 0, 0, 0, 0, 0));

        resetn = 1'b0;
        drive(0, 7, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("reset_state", obs(), 18'b1_00000_0_000_000000_0_0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            drive(tbl[i].v, tbl[i].fu, tbl[i].r1, tbl[i].u1, tbl[i].r2, tbl[i].u2, tbl[i].r3, tbl[i].we,
                  tbl[i].done);
            @(negedge clk);
            check($sformatf("vec%0d", i), obs(),
                  {tbl[i].e_rdy, tbl[i].e_start, tbl[i].e_wbv, tbl[i].e_wbfu, tbl[i].e_wbreg, tbl[i].e_wbwe,
                   tbl[i].e_err});
        end

        // reset with three entries in flight
        @(posedge clk); #1; drive(1, 0, 0, 0, 0, 0, 20, 1, 0);
        @(posedge clk); #1; drive(1, 1, 20, 1, 0, 0, 21, 1, 0);
        @(posedge clk); #1; drive(1, 2, 0, 0, 0, 0, 22, 1, 0);
        @(posedge clk); #1; drive(0, 7, 0, 0, 0, 0, 0, 0, 0); resetn = 1'b0;
        @(posedge clk); #1; resetn = 1'b1; drive(0, 0, 0, 0, 0, 0, 20, 1, 5'b00111);
        @(negedge clk);
        check("midflight_reset_idle", obs(), 18'b1_00000_0_000_000000_0_0);
        @(posedge clk); #1; drive(0, 7, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("stray_done_ignored", obs(), 18'b1_00000_0_000_000000_0_0);

        // random traffic against the model
        @(posedge clk); #1; resetn = 1'b0; drive(0, 7, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1; resetn = 1'b1;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            rv    = ($urandom_range(0, 9) < 7);
            rfu   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            rr1   = pick_reg();
            ru1   = 1'($urandom_range(0, 1));
            rr2   = pick_reg();
            ru2   = 1'($urandom_range(0, 1));
            rr3   = pick_reg();
            rwe   = ($urandom_range(0, 9) < 7);
            rdone = '0;
            for (int k = 0; k < 5; k++) rdone[k] = ($urandom_range(0, 9) < 3);
            drive(rv, rfu, rr1, ru1, rr2, ru2, rr3, rwe, rdone);
            @(negedge clk);
            model_cycle(rv, rfu, rr1, ru1, rr2, ru2, rr3, rwe, rdone, exp);
            check($sformatf("rand%0d", c), obs(), exp);
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sb_issue_ctrl.md
# sb_issue_ctrl

Scoreboard issue controller between the instruction decoder and the functional units (FUs). It accepts one decoded instruction per cycle, allocates it to its FU, and tracks RAW, WAR and WAW hazards over the 64-entry register space: GPRs 0–31 and HI/LO at 32. It pulses an FU start once the operands are available, and arbitrates FU writeback to the register file. It is a classic single-entry-per-FU scoreboard: no renaming, no flush.

## Interface
- NFU, 5, number of FUs; FU index = decoder `fu` field
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- id_valid  in  1  decoded instruction present
- id_ready  out  1  instruction accepted this cycle when id_valid & id_ready
- id_fu  in  3  target FU index
- id_reg1 / id_reg2  in  6 each  source register addresses
- id_r1_val / id_r2_val  in  1 each  source is actually read
- id_reg3  in  6  destination register
- id_rf_we  in  1  instruction writes id_reg3
- id_err  out  1  one-cycle pulse: accepted instruction had id_fu >= NFU and was discarded
- fu_start  out  NFU  one-hot-per-unit pulse: operands ready, FU begins
- fu_done  in  NFU  per-unit one-cycle pulse: result available
- wb_valid  out  1  writeback granted this cycle
- wb_fu  out  3  granted FU index
- wb_reg  out  6  destination register of granted FU
- wb_we  out  1  granted op writes the register file (its id_rf_we)

## Operation
- Per FU, one entry holds:
  - state: IDLE / WAIT / EXEC / DONE
  - fields: dst, we, src1, src2
  - ready flags: rdy1, rdy2
  - producer tags: q1, q2 (3b)
- Register result-status table: 64 × {busy, fu tag}. Register 0 is never marked busy and is always ready.
- Issue (id_ready): id_fu < NFU and entry[id_fu] is IDLE, and no WAW, i.e. not (id_rf_we & id_reg3≠0 & busy[id_reg3]).
  - id_fu >= NFU: id_ready=1, instruction dropped, id_err pulses.
- On issue:
  - Entry goes to WAIT.
  - For each source: rdy=1 if the source is not used, or is reg 0, or is not busy, or its producer is being written back this same cycle. Otherwise rdy=0 and q=producer tag.
  - If id_rf_we & id_reg3≠0: busy[id_reg3]=1, tag=id_fu.
- WAIT → EXEC: when rdy1 & rdy2, fu_start[i]=1 (combinational from registered state) for exactly one cycle; state is EXEC the next cycle.
- EXEC → DONE: on fu_done[i]. fu_done in any other state is ignored.
- Writeback eligibility for DONE entry i: no WAR. A WAR exists if any entry j≠i is in WAIT with (src1==dst_i & rdy1) or (src2==dst_i & rdy2), i.e. entry j has not read its operand yet. The check applies only when we_i & dst_i≠0.
- Arbitration: lowest-index eligible DONE entry wins; at most one grant per cycle. Outputs: wb_valid=1, wb_fu=i, wb_reg=dst_i, wb_we=we_i.
- On grant of entry i (effective next cycle):
  - Entry goes to IDLE.
  - busy[dst_i] clears only if its tag==i.
  - Every WAIT entry with rdyN=0 & qN==i sets rdyN=1.
- The same FU can be reissued the cycle after its grant, not in the grant cycle.

## Timing
- Reset, next posedge with resetn=0:
  - all entries IDLE; result-status table clear
  - fu_start=0, wb_valid=0, id_err=0; wb_fu/wb_reg/wb_we=0
  - id_ready=1 after reset
  - Reset mid-operation discards all entries; later fu_done pulses are ignored because the entries are IDLE.
- Latencies:
  - Issue at cycle T with operands ready → fu_start at T+1.
  - fu_done at D → DONE at D+1 → wb_valid at D+1 earliest.
  - Dependent rdy set at D+2; its fu_start at D+2.
- Same-cycle events:
  - Issue and writeback grant in the same cycle: an issuing source whose producer is granted is marked ready.
  - Issue reading busy[r] while grant clears r: issue sees the grant.
  - Issue writing busy[r] while a grant clears r: the issue write wins.
- Starvation: a DONE entry blocked by WAR waits until the blocking WAIT entries start. Lower-index priority is fixed.
- All outputs except id_ready, fu_start and wb_* are registered. id_ready, fu_start and wb_* are combinational from registered state and inputs.

## Test plan
- Independent ops: addiu r3←r1 (fu0) at T, lw r4 (fu3) at T+1 → fu_start[0] at T+1, fu_start[3] at T+2; done pulses both at T+5 → wb_fu=0 at T+6, wb_fu=3 at T+7.
- RAW: fu0 writes r5, then fu3 reads r5 → fu_start[3] is held until the cycle after wb of fu0 (fu_done[0] at D → fu_start[3] at D+2).
- WAW: fu0 in EXEC writing r7, then fu4 instruction writing r7 → id_ready=0 until the cycle after fu0's grant, then accepted.
- WAR: fu3 in WAIT reading r2 (blocked by RAW on another reg) while fu0 writes r2 and finishes → fu0 stays DONE, wb_valid=0 until the cycle after fu_start[3].
- Structural + arbitration: reissue to busy fu0 → id_ready=0. Simultaneous fu_done[2] and fu_done[4] → wb_fu=2 then wb_fu=4 on consecutive cycles.
- Reset mid-flight with three entries active → next cycle all idle, id_ready=1; stray fu_done[0] produces no wb_valid. id_fu=7 → id_err pulse, no start.
